// File: rtl/vending_change_dispenser.sv
// Coin-return sequencer: pays a balance out greedily, largest coin first, over a
// req/ack hopper handshake, tracking per-coin stock and reporting any shortfall.
module vending_change_dispenser #(
    parameter int kNumCoins   = 3,
    parameter int kTotalBits  = 31,
    parameter int kCoinVal0   = 100,
    parameter int kCoinVal1   = 500,
    parameter int kCoinVal2   = 1000,
    parameter int kStockBits  = 8,
    parameter int kInitStock  = 4,
    parameter int kAckTimeout = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_start,
    input  logic [kTotalBits-1:0]           i_amount,
    input  logic                            i_hopper_ack,
    input  logic                            i_refill_valid,
    input  logic [1:0]                      i_refill_idx,
    input  logic [kStockBits-1:0]           i_refill_count,
    output logic [kNumCoins-1:0]            o_return_coin,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_short,
    output logic                            o_fault,
    output logic [kTotalBits-1:0]           o_remaining,
    output logic [kNumCoins*kStockBits-1:0] o_stock
);

    localparam int kTimerBits = $clog2(kAckTimeout) + 1;
    localparam logic [kStockBits:0] kStockMax = (kStockBits+1)'((1 << kStockBits) - 1);

    typedef enum logic [1:0] {IDLE, SELECT, WAIT_ACK, DONE} state_t;

    state_t                 state_q, state_d;
    logic [kTotalBits-1:0]  remaining_q, remaining_d;
    logic [kNumCoins-1:0]   coin_q, coin_d;
    logic [1:0]             coinIdx_q, coinIdx_d;
    logic [kTimerBits-1:0]  timer_q, timer_d;
    logic                   short_q, short_d;
    logic                   fault_q, fault_d;
    logic [kStockBits-1:0]  stock_q [kNumCoins];
    logic [kStockBits-1:0]  stock_d [kNumCoins];
    logic                   pickFound;
    logic [1:0]             pickIdx;
    logic                   ackTaken;
    logic [kStockBits:0]    stockSum;

    function automatic logic [kTotalBits-1:0] coinValue(input int idx);
        case (idx)
            0:       return kTotalBits'(kCoinVal0);
            1:       return kTotalBits'(kCoinVal1);
            2:       return kTotalBits'(kCoinVal2);
            default: return '0;
        endcase
    endfunction

    // Later (larger) coins overwrite earlier matches, so the highest eligible index wins.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (stock_q[i] != '0 && coinValue(i) <= remaining_q) begin
                pickFound = 1'b1;
                pickIdx   = 2'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_d      = coin_q;
        coinIdx_d   = coinIdx_q;
        timer_d     = timer_q;
        short_d     = short_q;
        fault_d     = fault_q;
        ackTaken    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start && !fault_q) begin
                    state_d     = SELECT;
                    remaining_d = i_amount;
                    short_d     = 1'b0;
                end
            end
            SELECT: begin
                if (pickFound) begin
                    coin_d    = kNumCoins'(1) << pickIdx;
                    coinIdx_d = pickIdx;
                    timer_d   = '0;
                    state_d   = WAIT_ACK;
                end else begin
                    short_d = (remaining_q != '0);
                    state_d = DONE;
                end
            end
            WAIT_ACK: begin
                if (i_hopper_ack) begin
                    ackTaken    = 1'b1;
                    coin_d      = '0;
                    remaining_d = remaining_q - coinValue(int'(coinIdx_q));
                    state_d     = SELECT;
                end else if (timer_q == kTimerBits'(kAckTimeout - 1)) begin
                    fault_d = 1'b1;
                    coin_d  = '0;
                    short_d = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Refill and ack-decrement combine before saturating, so both land in one cycle.
    always_comb begin
        stockSum = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            stockSum = {1'b0, stock_q[i]};
            if (i_refill_valid && i_refill_idx == 2'(i))
                stockSum = stockSum + {1'b0, i_refill_count};
            if (ackTaken && coinIdx_q == 2'(i))
                stockSum = stockSum - (kStockBits+1)'(1);
            stock_d[i] = (stockSum > kStockMax) ? {kStockBits{1'b1}} : stockSum[kStockBits-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            coin_q      <= '0;
            coinIdx_q   <= '0;
            timer_q     <= '0;
            short_q     <= 1'b0;
            fault_q     <= 1'b0;
            for (int i = 0; i < kNumCoins; i++) stock_q[i] <= kStockBits'(kInitStock);
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_q      <= coin_d;
            coinIdx_q   <= coinIdx_d;
            timer_q     <= timer_d;
            short_q     <= short_d;
            fault_q     <= fault_d;
            for (int i = 0; i < kNumCoins; i++) stock_q[i] <= stock_d[i];
        end
    end

    for (genvar g = 0; g < kNumCoins; g++) begin : gStock
        assign o_stock[g*kStockBits +: kStockBits] = stock_q[g];
    end

    assign o_return_coin = coin_q;
    assign o_busy        = (state_q != IDLE);
    assign o_done        = (state_q == DONE);
    assign o_short       = short_q;
    assign o_fault       = fault_q;
    assign o_remaining   = remaining_q;

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Scoreboard bench for vending_change_dispenser: a greedy payout model queues the
// expected coins and final result, which are checked as the DUT produces them.
module tb_vending_change_dispenser;

    localparam int kAckTimeout = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic [30:0] i_amount;
    logic        i_hopper_ack;
    logic        i_refill_valid;
    logic [1:0]  i_refill_idx;
    logic [7:0]  i_refill_count;
    logic [2:0]  o_return_coin;
    logic        o_busy;
    logic        o_done;
    logic        o_short;
    logic        o_fault;
    logic [30:0] o_remaining;
    logic [23:0] o_stock;

    int          compared   = 0;
    int          mismatched = 0;
    int          mStock [3];
    int          coinVal [3] = '{100, 500, 1000};
    int          coinQ [$];
    logic [31:0] resultQ [$];

    always #5 clk = ~clk;

    vending_change_dispenser dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_amount      (i_amount),
        .i_hopper_ack  (i_hopper_ack),
        .i_refill_valid(i_refill_valid),
        .i_refill_idx  (i_refill_idx),
        .i_refill_count(i_refill_count),
        .o_return_coin (o_return_coin),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_short       (o_short),
        .o_fault       (o_fault),
        .o_remaining   (o_remaining),
        .o_stock       (o_stock)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkStock();
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("stock%0d", i), 32'(o_stock[i*8 +: 8]), 32'(mStock[i]));
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset_n        = 1'b0;
        i_start        = 1'b0;
        i_amount       = '0;
        i_hopper_ack   = 1'b0;
        i_refill_valid = 1'b0;
        i_refill_idx   = '0;
        i_refill_count = '0;
        for (int i = 0; i < 3; i++) mStock[i] = 4;
        coinQ.delete();
        resultQ.delete();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic refillStock(input int idx, input int count);
        @(negedge clk);
        i_refill_valid = 1'b1;
        i_refill_idx   = 2'(idx);
        i_refill_count = 8'(count);
        @(negedge clk);
        i_refill_valid = 1'b0;
        if (idx < 3) mStock[idx] = (mStock[idx] + count > 255) ? 255 : mStock[idx] + count;
        checkStock();
    endtask

    // Acks each coin one cycle after it appears; optionally refills alongside the first ack.
    task automatic serve(input int refillIdx, input int refillCount);
        bit          done = 1'b0;
        bit          refillPending = (refillIdx >= 0);
        logic [31:0] exp;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (o_done) begin
                done = 1'b1;
                if (resultQ.size() == 0) begin
                    checkOutput("resultQueueEmpty", 32'(o_done), 32'(0));
                end else begin
                    exp = resultQ.pop_front();
                    checkOutput("short", 32'(o_short), 32'(exp[31]));
                    checkOutput("remaining", 32'(o_remaining), {1'b0, exp[30:0]});
                end
                checkOutput("leftoverCoins", 32'(coinQ.size()), 32'(0));
                checkStock();
                @(negedge clk);
                checkOutput("donePulseWidth", 32'(o_done), 32'(0));
                checkOutput("busyAfterDone", 32'(o_busy), 32'(0));
            end else if (o_return_coin != '0) begin
                if (coinQ.size() == 0)
                    checkOutput("unexpectedCoin", 32'(o_return_coin), 32'(0));
                else
                    checkOutput("coin", 32'(o_return_coin), 32'(1) << coinQ.pop_front());
                i_hopper_ack = 1'b1;
                if (refillPending) begin
                    i_refill_valid = 1'b1;
                    i_refill_idx   = 2'(refillIdx);
                    i_refill_count = 8'(refillCount);
                    mStock[refillIdx] = (mStock[refillIdx] + refillCount > 255) ? 255 : mStock[refillIdx] + refillCount;
                    refillPending = 1'b0;
                end
                @(negedge clk);
                i_hopper_ack   = 1'b0;
                i_refill_valid = 1'b0;
            end
        end
        if (!done) checkOutput("payoutTimeout", 32'(0), 32'(1));
    endtask

    task automatic applyStimulus(input int amount, input int refillIdx, input int refillCount);
        int rem = amount;
        bit found;
        do begin
            found = 1'b0;
            for (int i = 2; i >= 0; i--) begin
                if (!found && mStock[i] > 0 && coinVal[i] <= rem) begin
                    found = 1'b1;
                    coinQ.push_back(i);
                    rem -= coinVal[i];
                    mStock[i]--;
                end
            end
        end while (found);
        resultQ.push_back({rem != 0, 31'(rem)});
        @(negedge clk);
        i_start  = 1'b1;
        i_amount = 31'(amount);
        @(negedge clk);
        i_start = 1'b0;
        checkOutput("busyAfterStart", 32'(o_busy), 32'(1));
        serve(refillIdx, refillCount);
    endtask

    initial begin
        int coinCycles;
        int donePulses;
        bit sawDone;
        bit firstCoin;

        reset_n        = 1'b0;
        i_start        = 1'b0;
        i_amount       = '0;
        i_hopper_ack   = 1'b0;
        i_refill_valid = 1'b0;
        i_refill_idx   = '0;
        i_refill_count = '0;
        resetDut();

        checkOutput("resetBusy", 32'(o_busy), 32'(0));
        checkOutput("resetDone", 32'(o_done), 32'(0));
        checkOutput("resetCoin", 32'(o_return_coin), 32'(0));
        checkOutput("resetFault", 32'(o_fault), 32'(0));
        checkOutput("resetShort", 32'(o_short), 32'(0));
        checkOutput("resetRemaining", 32'(o_remaining), 32'(0));
        checkStock();

        applyStimulus(1700, -1, 0);
        applyStimulus(0, -1, 0);

        resetDut();
        for (int n = 0; n < 4; n++) applyStimulus(1000, -1, 0);
        applyStimulus(1000, -1, 0);

        resetDut();
        applyStimulus(1050, -1, 0);

        resetDut();
        applyStimulus(100, 0, 3);
        refillStock(0, 255);
        refillStock(3, 10);

        // Hopper never acks: the request must time out and latch the fault.
        resetDut();
        @(negedge clk);
        i_start  = 1'b1;
        i_amount = 31'd1000;
        @(negedge clk);
        i_start    = 1'b0;
        coinCycles = 0;
        sawDone    = 1'b0;
        firstCoin  = 1'b1;
        for (int cyc = 0; cyc < 60 && !sawDone; cyc++) begin
            @(negedge clk);
            if (o_done) begin
                sawDone = 1'b1;
            end else if (o_return_coin != '0) begin
                if (firstCoin) checkOutput("timeoutCoin", 32'(o_return_coin), 32'(4));
                firstCoin = 1'b0;
                coinCycles++;
            end
        end
        checkOutput("timeoutReached", 32'(sawDone), 32'(1));
        checkOutput("timeoutCycles", 32'(coinCycles), 32'(kAckTimeout));
        checkOutput("timeoutFault", 32'(o_fault), 32'(1));
        checkOutput("timeoutShort", 32'(o_short), 32'(1));
        checkOutput("timeoutRemaining", 32'(o_remaining), 32'(1000));
        checkStock();
        @(negedge clk);
        i_start  = 1'b1;
        i_amount = 31'd500;
        @(negedge clk);
        i_start = 1'b0;
        checkOutput("startIgnoredOnFault", 32'(o_busy), 32'(0));
        checkOutput("faultSticky", 32'(o_fault), 32'(1));

        resetDut();
        checkOutput("faultClearedByReset", 32'(o_fault), 32'(0));
        @(negedge clk);
        i_start  = 1'b1;
        i_amount = 31'd500;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        checkOutput("preResetCoin", 32'(o_return_coin), 32'(2));
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncResetCoin", 32'(o_return_coin), 32'(0));
        checkOutput("asyncResetBusy", 32'(o_busy), 32'(0));
        checkStock();
        @(negedge clk);
        reset_n    = 1'b1;
        donePulses = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (o_done) donePulses++;
        end
        checkOutput("noDoneAfterReset", 32'(donePulses), 32'(0));
        checkOutput("idleAfterReset", 32'(o_busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
